// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline forwarding, load-use stall and hold controller
module pipe_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic                   id_wreg,
    input  logic                   id_m2reg,
    input  logic [4:0]             id_dest,
    input  logic                   ext_hold,
    output logic                   pc_we,
    output logic                   ifid_we,
    output logic                   idexe_bubble,
    output logic [2:0]             fwda,
    output logic [2:0]             fwdb,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam logic [1:0] S_RUN = 2'b00, S_LD = 2'b01, S_HOLD = 2'b10;
    logic       r_e_wreg, r_e_m2reg, r_m_wreg, r_m_m2reg, r_w_wreg;
    logic [4:0] r_e_dest, r_m_dest, r_w_dest;
    logic [1:0] r_state, w_next_state;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic       w_lu, w_stall;
    // Youngest producer wins; a load still in EXE falls through because lu covers it
    function automatic logic [2:0] f_fwd(input logic use_x, input logic [4:0] reg_x);
        if (!use_x || reg_x == 5'd0) return 3'b000;
        if (r_e_wreg && !r_e_m2reg && r_e_dest == reg_x) return 3'b001;
        if (r_m_wreg && r_m_m2reg && r_m_dest == reg_x) return 3'b011;
        if (r_m_wreg && r_m_dest == reg_x) return 3'b010;
        if (r_w_wreg && r_w_dest == reg_x) return 3'b100;
        return 3'b000;
    endfunction
    assign w_lu = r_e_wreg & r_e_m2reg & (r_e_dest != 5'd0) &
                  ((id_use_rs & (id_rs == r_e_dest)) | (id_use_rt & (id_rt == r_e_dest)));
    assign fwda = f_fwd(id_use_rs, id_rs);
    assign fwdb = f_fwd(id_use_rt, id_rt);
    // Shadow destination pipeline advances every cycle; stalls only insert bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_e_wreg, r_e_m2reg, r_e_dest} <= '0;
            {r_m_wreg, r_m_m2reg, r_m_dest} <= '0;
            {r_w_wreg, r_w_dest}            <= '0;
        end else begin
            r_e_wreg  <= idexe_bubble ? 1'b0 : id_wreg;
            r_e_m2reg <= idexe_bubble ? 1'b0 : id_m2reg;
            r_e_dest  <= idexe_bubble ? 5'd0 : id_dest;
            r_m_wreg  <= r_e_wreg;
            r_m_m2reg <= r_e_m2reg;
            r_m_dest  <= r_e_dest;
            r_w_wreg  <= r_m_wreg;
            r_w_dest  <= r_m_dest;
        end
    end
    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_next_state;
    end
    // FSM next state: hold dominates, load-use only entered from RUN
    always_comb begin
        w_next_state = ext_hold ? S_HOLD : (r_state == S_RUN && w_lu) ? S_LD : S_RUN;
    end
    // FSM outputs: front-end enables and bubble, forced to the reset pattern while rst
    always_comb begin
        state        = r_state;
        w_stall      = w_lu | ext_hold | ((r_state == S_HOLD) & ext_hold);
        pc_we        = !rst && !w_stall;
        ifid_we      = !rst && !w_stall;
        idexe_bubble = rst || w_stall;
    end
    // Saturating count of frozen-PC cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  r_stall_cnt <= '0;
        else if (!pc_we && r_stall_cnt != '1)     r_stall_cnt <= r_stall_cnt + 1'b1;
    end
    assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of forwarding, load-use, hold and counter saturation
module tb_pipe_hazard_ctrl;
    logic        clk, rst;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_use_rs, id_use_rt, id_wreg, id_m2reg, ext_hold;
    logic        pc_we, ifid_we, idexe_bubble;
    logic [2:0]  fwda, fwdb;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic        pc_we4, ifid_we4, idexe_bubble4;
    logic [2:0]  fwda4, fwdb4;
    logic [1:0]  state4;
    logic [3:0]  stall_cnt4;
    int          errors = 0;
    int          checks = 0;

    pipe_hazard_ctrl #(.STALL_CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
        .id_m2reg(id_m2reg), .id_dest(id_dest), .ext_hold(ext_hold),
        .pc_we(pc_we), .ifid_we(ifid_we), .idexe_bubble(idexe_bubble),
        .fwda(fwda), .fwdb(fwdb), .state(state), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.STALL_CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
        .id_m2reg(id_m2reg), .id_dest(id_dest), .ext_hold(ext_hold),
        .pc_we(pc_we4), .ifid_we(ifid_we4), .idexe_bubble(idexe_bubble4),
        .fwda(fwda4), .fwdb(fwdb4), .state(state4), .stall_cnt(stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic wr, input logic m2, input logic [4:0] dest);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wreg = wr; id_m2reg = m2; id_dest = dest;
    endtask

    task automatic ctl(input string tag, input logic pw, input logic [1:0] st, input logic [15:0] cnt);
        chk({tag, "_pc_we"}, 32'(pc_we), 32'(pw));
        chk({tag, "_ifid_we"}, 32'(ifid_we), 32'(pw));
        chk({tag, "_bubble"}, 32'(idexe_bubble), 32'(!pw));
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_cnt"}, 32'(stall_cnt), 32'(cnt));
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ext_hold = 1'b0;
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        #1;
        ctl("reset", 1'b0, 2'b00, 16'd0);
        chk("reset_fwda", 32'(fwda), 32'd0);
        chk("reset_fwdb", 32'(fwdb), 32'd0);
        tick; rst = 1'b0;
        // add $3,$1,$2 ; sub $4,$3,$5
        #1; ctl("add", 1'b1, 2'b00, 16'd0);
        tick; set_id(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4); #1;
        chk("alu_fwda", 32'(fwda), 32'd1);
        chk("alu_fwdb", 32'(fwdb), 32'd0);
        ctl("alu", 1'b1, 2'b00, 16'd0);
        // lw $3,0($1) ; add $4,$3,$3
        tick; set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3); #1;
        ctl("lw", 1'b1, 2'b00, 16'd0);
        tick; set_id(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4); #1;
        ctl("lu", 1'b0, 2'b00, 16'd0);
        tick; #1;
        ctl("lu_after", 1'b1, 2'b01, 16'd1);
        chk("lu_fwda", 32'(fwda), 32'd3);
        chk("lu_fwdb", 32'(fwdb), 32'd3);
        tick; #1;
        chk("lu_back_run", 32'(state), 32'd0);
        // add $0,$1,$2 ; or $5,$0,$0 ; lw $0 ; use $0
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
        tick; set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5); #1;
        chk("r0_fwda", 32'(fwda), 32'd0);
        chk("r0_fwdb", 32'(fwdb), 32'd0);
        ctl("r0", 1'b1, 2'b00, 16'd1);
        tick; set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
        tick; set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6); #1;
        ctl("lw_r0", 1'b1, 2'b00, 16'd1);
        chk("lw_r0_fwda", 32'(fwda), 32'd0);
        // producer $7, two independent, consumer -> WB
        tick; set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7);
        tick; set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
        tick; set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9);
        tick; set_id(5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10); #1;
        chk("wb_fwda", 32'(fwda), 32'd4);
        chk("wb_fwdb", 32'(fwdb), 32'd0);
        // producer $7, one independent, consumer -> MEM ALU
        tick; set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7);
        tick; set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
        tick; set_id(5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd11); #1;
        chk("mem_fwda", 32'(fwda), 32'd0);
        chk("mem_fwdb", 32'(fwdb), 32'd2);
        ctl("mem", 1'b1, 2'b00, 16'd1);
        // load-use with simultaneous 3-cycle hold
        tick; set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        tick; set_id(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4); ext_hold = 1'b1; #1;
        ctl("hold_c0", 1'b0, 2'b00, 16'd1);
        tick; #1; ctl("hold_c1", 1'b0, 2'b10, 16'd2);
        tick; #1; ctl("hold_c2", 1'b0, 2'b10, 16'd3);
        tick; ext_hold = 1'b0; #1;
        ctl("hold_rel", 1'b1, 2'b10, 16'd4);
        chk("hold_rel_fwda", 32'(fwda), 32'd0);
        tick; set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0); ext_hold = 1'b1; #1;
        ctl("hold_c4", 1'b0, 2'b00, 16'd4);
        // long hold: 4-bit counter saturates
        repeat (11) tick;
        #1; chk("sat4_reach", 32'(stall_cnt4), 32'd15);
        repeat (9) tick;
        #1;
        chk("sat4_stay", 32'(stall_cnt4), 32'd15);
        ctl("long_hold", 1'b0, 2'b10, 16'd24);
        // asynchronous reset mid-hold
        #1; rst = 1'b1; #1;
        ctl("arst", 1'b0, 2'b00, 16'd0);
        chk("arst_cnt4", 32'(stall_cnt4), 32'd0);
        chk("arst_fwda", 32'(fwda), 32'd0);
        tick; ext_hold = 1'b0; rst = 1'b0; #1;
        ctl("post_rst", 1'b1, 2'b00, 16'd0);
        tick; #1;
        ctl("post_rst2", 1'b1, 2'b00, 16'd0);
        chk("post_rst_cnt4", 32'(stall_cnt4), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
